// File: rtl/hb_tx_cmd_sched.sv
// hb_tx_cmd_sched: heartbeat/send timers plus a PLCA-priority arbiter for the shared PCS tx_cmd path.
// Define HB_SCHED_STATS_EN to build the saturating preemption counter (otherwise tied to 0).
module hb_tx_cmd_timer #(
   parameter int RELOAD = 64,
   parameter int CNT_W  = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic start,
   output logic done
);
   logic [CNT_W-1:0] count;
   // start outranks expiry, so a restart on the 1->0 cycle keeps done low
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         done  <= 1'b1;
      end else if (start) begin
         count <= CNT_W'(RELOAD);
         done  <= 1'b0;
      end else if (count != '0) begin
         count <= count - 1'b1;
         done  <= (count == CNT_W'(1));
      end
   end
endmodule

module hb_tx_cmd_sched #(
   parameter int HB_TIMER_CYCLES = 20000,
   parameter int HB_SEND_CYCLES  = 64,
   parameter int GAP_CYCLES      = 2,
   parameter int CNT_W           = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       hb_timer_start,
   input  logic       hb_send_timer_start,
   input  logic [1:0] hb_cmd,
   input  logic [1:0] plca_cmd,
   input  logic       tx_busy,
   output logic       hb_timer_done,
   output logic       hb_send_timer_done,
   output logic [1:0] tx_cmd,
   output logic       hb_grant,
   output logic       hb_preempt,
   output logic [7:0] hb_preempt_cnt
);
   localparam logic [1:0] NONE = 2'b11;
   localparam int GW = $clog2(GAP_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, PLCA, HB, GAP} state_t;
   state_t state, state_nx;
   logic [GW-1:0] gap_cnt;
   logic plca_req, hb_req, gap_end, preempt_nx;
   hb_tx_cmd_timer #(.RELOAD(HB_TIMER_CYCLES), .CNT_W(CNT_W)) u_hb_timer (
      .clk(clk), .reset_n(reset_n), .start(hb_timer_start), .done(hb_timer_done)
   );
   hb_tx_cmd_timer #(.RELOAD(HB_SEND_CYCLES), .CNT_W(CNT_W)) u_hb_send_timer (
      .clk(clk), .reset_n(reset_n), .start(hb_send_timer_start), .done(hb_send_timer_done)
   );
   assign plca_req   = plca_cmd != NONE;
   assign hb_req     = hb_cmd != NONE;
   assign gap_end    = gap_cnt == GW'(GAP_CYCLES - 1);
   assign preempt_nx = state == HB && state_nx == PLCA;
   assign hb_grant   = state == HB;
   // PLCA wins from every state; the guard gap only holds off heartbeat traffic
   always_comb begin
      state_nx = IDLE;
      if (enable)
         case (state)
            IDLE:    state_nx = plca_req ? PLCA : (hb_req && !tx_busy) ? HB : IDLE;
            PLCA:    state_nx = plca_req ? PLCA : IDLE;
            HB:      state_nx = plca_req ? PLCA : (!hb_req || tx_busy) ? GAP : HB;
            GAP:     state_nx = plca_req ? PLCA : gap_end ? IDLE : GAP;
            default: state_nx = IDLE;
         endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         gap_cnt    <= '0;
         tx_cmd     <= NONE;
         hb_preempt <= 1'b0;
      end else begin
         state      <= state_nx;
         gap_cnt    <= (state == GAP && state_nx == GAP) ? gap_cnt + 1'b1 : '0;
         tx_cmd     <= state_nx == PLCA ? plca_cmd : state_nx == HB ? hb_cmd : NONE;
         hb_preempt <= preempt_nx;
      end
   end
`ifdef HB_SCHED_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         hb_preempt_cnt <= '0;
      else if (preempt_nx && hb_preempt_cnt != 8'hff)
         hb_preempt_cnt <= hb_preempt_cnt + 1'b1;
   end
`else
   assign hb_preempt_cnt = '0;
`endif
endmodule

// File: tb/tb_hb_tx_cmd_sched.sv
// tb_hb_tx_cmd_sched: randomized + directed stimulus, expectations queued from a rule-level model and popped by a monitor.
module tb_hb_tx_cmd_sched;
   localparam int HBT = 100, HBS = 64, GAP = 2;
   localparam logic [1:0] N = 2'b11;
   logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, hb_timer_start = 1'b0, hb_send_timer_start = 1'b0, tx_busy = 1'b0;
   logic [1:0] hb_cmd = N, plca_cmd = N;
   logic hb_timer_done, hb_send_timer_done, hb_grant, hb_preempt;
   logic [1:0] tx_cmd;
   logic [7:0] hb_preempt_cnt;
   always #5 clk = ~clk;
   hb_tx_cmd_sched #(.HB_TIMER_CYCLES(HBT), .HB_SEND_CYCLES(HBS), .GAP_CYCLES(GAP), .CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .hb_timer_start(hb_timer_start),
      .hb_send_timer_start(hb_send_timer_start), .hb_cmd(hb_cmd), .plca_cmd(plca_cmd), .tx_busy(tx_busy),
      .hb_timer_done(hb_timer_done), .hb_send_timer_done(hb_send_timer_done), .tx_cmd(tx_cmd),
      .hb_grant(hb_grant), .hb_preempt(hb_preempt), .hb_preempt_cnt(hb_preempt_cnt)
   );
   typedef struct packed {logic [1:0] cmd; logic grant, pre, td, sd; logic [7:0] pc;} exp_t;
   exp_t q[$];
   exp_t mon_e;
   int n_cmp = 0, n_bad = 0;
   int m_edge, t_at, s_at, own, gap_left, pcnt;
   task automatic chk(input string nm, input int act, input int want);
      n_cmp++;
      if (act != want) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, want);
      end
   endtask
   // owner: 0 idle, 1 plca, 2 heartbeat, 3 guard gap
   task automatic model(input logic en, ts, ss, input logic [1:0] h, p, input logic b);
      exp_t e;
      logic pre = 1'b0;
      m_edge++;
      if (ts) t_at = m_edge + HBT;
      if (ss) s_at = m_edge + HBS;
      if (!en) own = 0;
      else if (p != N) begin pre = (own == 2); own = 1; end
      else if (own == 1) own = 0;
      else if (own == 2) begin if (h == N || b) begin own = 3; gap_left = GAP; end end
      else if (own == 3) begin gap_left--; if (gap_left == 0) own = 0; end
      else if (h != N && !b) own = 2;
`ifdef HB_SCHED_STATS_EN
      if (pre && pcnt < 255) pcnt++;
`endif
      e.cmd = own == 1 ? p : own == 2 ? h : N;
      e.grant = own == 2;
      e.pre = pre;
      e.td = m_edge >= t_at;
      e.sd = m_edge >= s_at;
      e.pc = 8'(pcnt);
      q.push_back(e);
   endtask
   task automatic drive(input logic en, ts, ss, input logic [1:0] h, p, input logic b);
      enable = en; hb_timer_start = ts; hb_send_timer_start = ss; hb_cmd = h; plca_cmd = p; tx_busy = b;
      model(en, ts, ss, h, p, b);
   endtask
   task automatic step(input logic en, ts, ss, input logic [1:0] h, p, input logic b);
      @(negedge clk);
      drive(en, ts, ss, h, p, b);
   endtask
   task automatic idle(input int n);
      repeat (n) step(1, 0, 0, N, N, 0);
   endtask
   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("rst_tx_cmd", tx_cmd, N);
      chk("rst_grant", hb_grant, 0);
      chk("rst_preempt", hb_preempt, 0);
      chk("rst_cnt", hb_preempt_cnt, 0);
      chk("rst_td", hb_timer_done, 1);
      chk("rst_sd", hb_send_timer_done, 1);
      m_edge = 0; t_at = 0; s_at = 0; own = 0; gap_left = 0; pcnt = 0;
      @(negedge clk);
      reset_n = 1'b1;
      drive(1, 0, 0, N, N, 0);
   endtask
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         chk("tx_cmd", tx_cmd, mon_e.cmd);
         chk("hb_grant", hb_grant, mon_e.grant);
         chk("hb_preempt", hb_preempt, mon_e.pre);
         chk("hb_timer_done", hb_timer_done, mon_e.td);
         chk("hb_send_timer_done", hb_send_timer_done, mon_e.sd);
         chk("hb_preempt_cnt", hb_preempt_cnt, mon_e.pc);
      end
   end
   initial begin
      logic [1:0] h, p;
      logic b;
      do_reset();
      step(1, 0, 1, N, N, 0); idle(70);
      step(1, 0, 1, N, N, 0); idle(29);
      step(1, 0, 1, N, N, 0); idle(70);
      step(1, 0, 1, N, N, 0); idle(63);
      step(1, 0, 1, N, N, 0); idle(70);
      step(1, 1, 0, N, N, 0); idle(105);
      repeat (3) step(1, 0, 0, 2'b10, N, 0);
      idle(4);
      repeat (2) step(1, 0, 0, 2'b10, N, 0);
      repeat (2) step(1, 0, 0, 2'b10, 2'b00, 0);
      idle(4);
      repeat (3) step(1, 0, 0, 2'b10, N, 1);
      repeat (2) step(1, 0, 0, 2'b10, N, 0);
      step(1, 0, 0, N, N, 0);
      step(1, 0, 0, N, 2'b01, 0);
      idle(3);
      repeat (2) step(1, 0, 0, 2'b10, N, 1'b0);
      step(1, 1, 1, 2'b10, N, 0);
      do_reset();
      repeat (2) step(1, 0, 0, N, 2'b00, 0);
      step(0, 0, 0, N, 2'b00, 0);
      idle(3);
      h = N; b = 1'b0;
      repeat (2500) begin
         if ($urandom_range(0, 3) == 0) h = 2'($urandom);
         if ($urandom_range(0, 7) == 0) b = ~b;
         p = ($urandom_range(0, 3) == 0) ? 2'($urandom) : N;
         step($urandom_range(0, 19) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 49) == 0, h, p, b);
      end
      idle(2);
      repeat (3) @(posedge clk);
      #2;
      chk("queue_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
